// File: rtl/line_clear_scanner_pkg.sv
// Shared constants, types and helpers for the line-clear scanner.
// Board geometry, empty-cell colour and the scan FSM encoding live here.
package line_clear_scanner_pkg;

   localparam int COLS    = 10;
   localparam int ROWS    = 20;
   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 1024;
   localparam int TIMER_W = $clog2(TIMEOUT);

   localparam logic [DATA_W-1:0] BG_COLOR = 16'h000F;
   localparam logic [2:0]        MAX_RUN  = 3'd4;

   typedef logic [COLS-1:0][DATA_W-1:0] row_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_EVAL,
      S_CLR_WAITVS,
      S_CLR_WAITLOW,
      S_FIN
   } scan_state_t;

   function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [2:0] inc);
      logic [16:0] sum;
      sum = {1'b0, acc} + {14'd0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/line_clear_scanner_if.sv
// Handshake bundle between the scanner (master) and the VRAM row path / game logic (slave).
// The scanner owns row requests, clear commands and status; the slave owns row data and timing.
interface line_clear_scanner_if;
   import line_clear_scanner_pkg::*;

   logic        start;
   logic        vs;
   logic        row_ready;
   row_t        read_reg;
   logic        row_ld;
   logic [7:0]  row;
   logic [7:0]  clear_row;
   logic [7:0]  clear_num_rows;
   logic        clear_the_row_ho;
   logic        busy;
   logic        done;
   logic [15:0] total_lines;

   modport master (
      input  start, vs, row_ready, read_reg,
      output row_ld, row, clear_row, clear_num_rows, clear_the_row_ho, busy, done, total_lines
   );

   modport slave (
      output start, vs, row_ready, read_reg,
      input  row_ld, row, clear_row, clear_num_rows, clear_the_row_ho, busy, done, total_lines
   );

endinterface

// File: rtl/line_clear_scanner_row_full_check.sv
// Combinational row-full detector: a row is full when no cell holds the background colour.
module line_clear_scanner_row_full_check
   import line_clear_scanner_pkg::*;
(
   input  row_t cells,
   output logic full
);

   always_comb begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         if (cells[c] == BG_COLOR) full = 1'b0;
      end
   end

endmodule

// File: rtl/line_clear_scanner.sv
// Bottom-up playfield scanner: reads rows through the VRAM handshake, finds the lowest run of
// full rows (up to four), commands the writer to collapse it across one vblank, and rescans.
module line_clear_scanner
   import line_clear_scanner_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   line_clear_scanner_if.master  bus
);

   scan_state_t        state_q, state_d;
   logic [7:0]         r_q, r_d;
   logic [2:0]         run_q, run_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   row_t               buf_q, buf_d;
   logic [7:0]         clear_row_q, clear_row_d;
   logic [7:0]         clear_num_q, clear_num_d;
   logic [15:0]        total_q, total_d;
   logic               row_ld_q, row_ld_d;
   logic               ho_q, ho_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               full;
   logic [2:0]         run_upd;

   line_clear_scanner_row_full_check u_full (
      .cells (buf_q),
      .full  (full)
   );

   // NOTE: every always_comb target gets a default first; a path that skips one would infer a latch.
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      run_d       = run_q;
      timer_d     = timer_q;
      buf_d       = buf_q;
      clear_row_d = clear_row_q;
      clear_num_d = clear_num_q;
      total_d     = total_q;

      run_upd = run_q;
      if (full && run_q < MAX_RUN) run_upd = run_q + 3'd1;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               r_d     = 8'(ROWS - 1);
               run_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.row_ready) begin
               buf_d   = bus.read_reg;
               state_d = S_EVAL;
            end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
               state_d = S_REQ;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         S_EVAL: begin
            run_d = run_upd;
            if (full && run_q == '0) clear_row_d = r_q;
            // A run ends at four rows, at the first non-full row above it, or at the top row.
            if (run_upd == MAX_RUN || (!full && run_q != '0) || (r_q == '0 && run_upd != '0)) begin
               clear_num_d = {5'd0, run_upd};
               state_d     = S_CLR_WAITVS;
            end else if (r_q == '0) begin
               state_d = S_FIN;
            end else begin
               r_d     = r_q - 8'd1;
               state_d = S_REQ;
            end
         end
         S_CLR_WAITVS: begin
            if (bus.vs) state_d = S_CLR_WAITLOW;
         end
         S_CLR_WAITLOW: begin
            if (!bus.vs) begin
               total_d = sat_add(total_q, run_q);
               run_d   = '0;
               r_d     = 8'(ROWS - 1);
               state_d = S_REQ;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Status outputs follow the next state so they register alongside it.
      row_ld_d = (state_d == S_REQ);
      ho_d     = (state_d == S_CLR_WAITVS) || (state_d == S_CLR_WAITLOW);
      busy_d   = (state_d != S_IDLE) && (state_d != S_FIN);
      done_d   = (state_d == S_FIN);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         r_q         <= 8'(ROWS - 1);
         run_q       <= '0;
         timer_q     <= '0;
         clear_row_q <= '0;
         clear_num_q <= '0;
         total_q     <= '0;
         row_ld_q    <= 1'b0;
         ho_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         run_q       <= run_d;
         timer_q     <= timer_d;
         clear_row_q <= clear_row_d;
         clear_num_q <= clear_num_d;
         total_q     <= total_d;
         row_ld_q    <= row_ld_d;
         ho_q        <= ho_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // NOTE: the row buffer is pure datapath, always written in WAIT before EVAL reads it, so it has no reset.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign bus.row_ld           = row_ld_q;
   assign bus.row              = r_q;
   assign bus.clear_row        = clear_row_q;
   assign bus.clear_num_rows   = clear_num_q;
   assign bus.clear_the_row_ho = ho_q;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.total_lines      = total_q;

endmodule

// File: tb/tb_line_clear_scanner.sv
// Scoreboard bench: a board-level reference model predicts row reads, clears and final totals;
// a responder plays the VRAM reader/writer and a monitor compares DUT activity against the queues.
module tb_line_clear_scanner;
   import line_clear_scanner_pkg::*;

   localparam int BUDGET = 20000;

   typedef struct {
      bit is_done;
      int row;
      int num;
      int total;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   line_clear_scanner_if bus ();

   line_clear_scanner dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   int   exp_rows[$];
   exp_t exp_evt[$];

   logic [DATA_W-1:0] load_board [ROWS][COLS];
   int load_seq     = 0;
   int withhold_seq = 0;
   int withheld_cnt = 0;
   int tot_model    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic flag_fail(input string name, input string what);
      n_vec++;
      n_miss++;
      $display("FAIL %s: %s", name, what);
   endtask

   // Vertical blank: high 7 cycles out of every 37, changed just after the rising edge.
   initial begin
      bus.vs = 1'b0;
      forever begin
         for (int i = 0; i < 37; i++) begin
            @(posedge clk);
            #2 bus.vs = (i < 7);
         end
      end
   end

   // VRAM side: answers row requests from its board image and collapses rows when a clear releases.
   initial begin : responder
      logic [DATA_W-1:0] board [ROWS][COLS];
      int   my_load;
      int   my_hold;
      int   r;
      int   cr;
      int   cn;
      logic ho_prev;
      my_load = 0;
      my_hold = 0;
      cr = 0;
      cn = 0;
      ho_prev = 1'b0;
      bus.row_ready = 1'b0;
      bus.read_reg  = '0;
      forever begin
         @(negedge clk);
         if (my_load != load_seq) begin
            board   = load_board;
            my_load = load_seq;
         end
         if (reset) begin
            ho_prev = 1'b0;
         end else begin
            if (bus.clear_the_row_ho && !ho_prev) begin
               cr = int'(bus.clear_row);
               cn = int'(bus.clear_num_rows);
            end
            if (!bus.clear_the_row_ho && ho_prev && cr < ROWS && cn > 0) begin
               for (int y = cr; y >= 0; y--) begin
                  for (int c = 0; c < COLS; c++) begin
                     if (y >= cn) board[y][c] = board[y-cn][c];
                     else         board[y][c] = BG_COLOR;
                  end
               end
            end
            ho_prev = bus.clear_the_row_ho;
            if (bus.row_ld) begin
               r = int'(bus.row);
               if (my_hold != withhold_seq) begin
                  my_hold = withhold_seq;
                  @(negedge clk);
                  withheld_cnt++;
               end else if (r < ROWS) begin
                  repeat ($urandom_range(1, 3)) @(negedge clk);
                  for (int c = 0; c < COLS; c++) bus.read_reg[c] = board[r][c];
                  bus.row_ready = 1'b1;
                  @(negedge clk);
                  bus.row_ready = 1'b0;
                  for (int c = 0; c < COLS; c++) bus.read_reg[c] = 16'($urandom);
               end
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT requests a row, raises a clear, or finishes.
   initial begin : monitor
      logic ho_prev;
      logic saw_vs;
      int   mon_hold;
      int   last_row;
      exp_t e;
      ho_prev  = 1'b0;
      saw_vs   = 1'b0;
      mon_hold = 0;
      last_row = -1;
      forever begin
         @(negedge clk);
         if (reset) begin
            ho_prev  = 1'b0;
            saw_vs   = 1'b0;
            last_row = -1;
         end else begin
            if (bus.row_ld) begin
               if (withheld_cnt != mon_hold) begin
                  mon_hold = withheld_cnt;
                  check("row_ld_retry_row", bus.row, last_row);
               end else if (exp_rows.size() == 0) begin
                  flag_fail("row_ld_unexpected", $sformatf("row_ld for row %0d, none required", bus.row));
               end else begin
                  last_row = exp_rows.pop_front();
                  check("row_ld_row", bus.row, last_row);
               end
            end
            if (bus.clear_the_row_ho && !ho_prev) begin
               saw_vs = 1'b0;
               if (exp_evt.size() == 0) begin
                  flag_fail("clear_unexpected", $sformatf("clear row %0d x%0d, none required",
                                                          bus.clear_row, bus.clear_num_rows));
               end else begin
                  e = exp_evt.pop_front();
                  check("clear_not_done", e.is_done, 0);
                  check("clear_row", bus.clear_row, e.row);
                  check("clear_num_rows", bus.clear_num_rows, e.num);
               end
            end
            if (bus.clear_the_row_ho && bus.vs) saw_vs = 1'b1;
            if (!bus.clear_the_row_ho && ho_prev) begin
               check("ho_held_through_vs_high", saw_vs, 1);
               check("ho_released_vs_low", bus.vs, 0);
            end
            ho_prev = bus.clear_the_row_ho;
            if (bus.done) begin
               if (exp_evt.size() == 0) begin
                  flag_fail("done_unexpected", $sformatf("done with total %0d, none required", bus.total_lines));
               end else begin
                  e = exp_evt.pop_front();
                  check("done_kind", e.is_done, 1);
                  check("total_lines", bus.total_lines, e.total);
                  check("busy_at_done", bus.busy, 0);
                  check("rows_unread_at_done", exp_rows.size(), 0);
               end
            end
         end
      end
   end

   // Reference model: repeatedly find the lowest full row, take up to four contiguous full rows above it,
   // record the rows the scanner must read to discover that, then collapse the board and rescan.
   task automatic model_scan();
      bit   f [ROWS];
      int   low;
      int   len;
      int   last;
      exp_t e;
      for (int r = 0; r < ROWS; r++) begin
         f[r] = 1'b1;
         for (int c = 0; c < COLS; c++) if (load_board[r][c] == BG_COLOR) f[r] = 1'b0;
      end
      forever begin
         low = -1;
         for (int r = ROWS - 1; r >= 0; r--) begin
            if (f[r]) begin
               low = r;
               break;
            end
         end
         if (low < 0) begin
            for (int r = ROWS - 1; r >= 0; r--) exp_rows.push_back(r);
            e = '{is_done: 1'b1, row: 0, num: 0, total: tot_model};
            exp_evt.push_back(e);
            return;
         end
         len = 0;
         while (len < 4 && low - len >= 0 && f[low-len]) len++;
         last = (len == 4 || low - len < 0) ? low - len + 1 : low - len;
         for (int r = ROWS - 1; r >= last; r--) exp_rows.push_back(r);
         e = '{is_done: 1'b0, row: low, num: len, total: 0};
         exp_evt.push_back(e);
         tot_model = (tot_model + len > 65535) ? 65535 : tot_model + len;
         for (int y = low; y >= 0; y--) begin
            if (y >= len) f[y] = f[y-len];
            else          f[y] = 1'b0;
         end
      end
   endtask

   function automatic logic [DATA_W-1:0] occ_color();
      logic [DATA_W-1:0] v;
      v = 16'($urandom);
      return (v == BG_COLOR) ? 16'h1234 : v;
   endfunction

   task automatic set_row(input int r, input bit full);
      for (int c = 0; c < COLS; c++) load_board[r][c] = full ? occ_color() : BG_COLOR;
   endtask

   task automatic clear_board();
      for (int r = 0; r < ROWS; r++) set_row(r, 1'b0);
   endtask

   task automatic rand_row(input int r);
      int hole;
      if ($urandom_range(0, 99) < 40) begin
         set_row(r, 1'b1);
      end else if ($urandom_range(0, 99) < 30) begin
         set_row(r, 1'b0);
      end else begin
         for (int c = 0; c < COLS; c++) load_board[r][c] = ($urandom_range(0, 1) != 0) ? occ_color() : BG_COLOR;
         hole = $urandom_range(0, COLS - 1);
         load_board[r][hole] = BG_COLOR;
      end
   endtask

   task automatic commit_board();
      load_seq++;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_rows.delete();
      exp_evt.delete();
      tot_model = 0;
      @(negedge clk);
   endtask

   task automatic run_scan(input bit restart_mid);
      int cyc;
      commit_board();
      model_scan();
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      cyc = 0;
      while (!bus.done && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         bus.start = restart_mid && (cyc == 40);
      end
      bus.start = 1'b0;
      if (!bus.done) begin
         flag_fail("done_timeout", $sformatf("no done within %0d cycles", BUDGET));
         do_reset();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int cyc;
      int top;
      bus.start = 1'b0;
      clear_board();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("rst_row_ld", bus.row_ld, 0);
      check("rst_row", bus.row, ROWS - 1);
      check("rst_clear_row", bus.clear_row, 0);
      check("rst_clear_num_rows", bus.clear_num_rows, 0);
      check("rst_ho", bus.clear_the_row_ho, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_total_lines", bus.total_lines, 0);

      // Empty board, with a second start pulse while busy.
      clear_board();
      run_scan(1'b1);

      // Bottom row full only.
      clear_board();
      set_row(19, 1'b1);
      run_scan(1'b0);

      // Four-row run at the bottom.
      clear_board();
      for (int r = 16; r < ROWS; r++) set_row(r, 1'b1);
      run_scan(1'b0);

      // Two runs separated by an empty row.
      clear_board();
      set_row(19, 1'b1);
      set_row(18, 1'b1);
      set_row(16, 1'b1);
      run_scan(1'b0);

      // Five-row run reaching the top row.
      clear_board();
      for (int r = 0; r < 5; r++) set_row(r, 1'b1);
      run_scan(1'b0);

      // Withheld row_ready forces a timeout and a re-request of the same row.
      clear_board();
      set_row(19, 1'b1);
      withhold_seq++;
      run_scan(1'b0);

      for (int t = 0; t < 25; t++) begin
         clear_board();
         top = (t % 5 == 0) ? 0 : 8;
         for (int r = top; r < ROWS; r++) rand_row(r);
         run_scan(1'b0);
      end

      // Reset while the clear command is held in its low-vblank wait.
      clear_board();
      set_row(19, 1'b1);
      commit_board();
      model_scan();
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      cyc = 0;
      while (!(bus.clear_the_row_ho && bus.vs) && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      if (!(bus.clear_the_row_ho && bus.vs)) flag_fail("rst_mid_timeout", "clear with vs high never seen");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_ho", bus.clear_the_row_ho, 0);
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_total_lines", bus.total_lines, 0);
      check("rst_mid_row_ld", bus.row_ld, 0);
      reset = 1'b0;
      exp_rows.delete();
      exp_evt.delete();
      tot_model = 0;
      repeat (60) @(negedge clk);
      check("rst_mid_idle_busy", bus.busy, 0);

      // Recovery after reset.
      clear_board();
      set_row(19, 1'b1);
      set_row(18, 1'b1);
      run_scan(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
